// File: rtl/commit_monitor.sv
// Difftest commit-stream monitor: PC continuity check, retired counter, ebreak halt,
// no-commit watchdog and a record FIFO drained over valid/ready.
module commit_monitor #(
  parameter int unsigned            PC_WIDTH     = 32,
  parameter int unsigned            INSTR_WIDTH  = 32,
  parameter int unsigned            FIFO_DEPTH   = 8,
  parameter int unsigned            CNT_WIDTH    = 32,
  parameter int unsigned            WDT_CYCLES   = 1024,
  parameter logic [PC_WIDTH-1:0]    RESET_PC     = 32'h80000000,
  parameter logic [INSTR_WIDTH-1:0] EBREAK_INSTR = 32'h00100073
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   diff_enable,
  input  logic [PC_WIDTH-1:0]    diff_PC,
  input  logic [INSTR_WIDTH-1:0] diff_Instr,
  input  logic [PC_WIDTH-1:0]    nextPC,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [PC_WIDTH-1:0]    rec_pc,
  output logic [INSTR_WIDTH-1:0] rec_instr,
  output logic [CNT_WIDTH-1:0]   retired_cnt,
  output logic                   halted,
  output logic                   err_flow,
  output logic [PC_WIDTH-1:0]    err_pc,
  output logic                   err_overflow,
  output logic                   wdt_timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned WW = $clog2(WDT_CYCLES) + 1;

  typedef enum logic [1:0] {WAIT_FIRST, RUN, HALTED} state_t;
  state_t state, state_nxt;

  logic [PC_WIDTH-1:0]    expected_pc;
  logic [WW-1:0]          wdt_cnt;
  logic [PC_WIDTH-1:0]    pc_mem    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [AW:0]            count;
  logic                   commit, is_ebreak, full, pop, push;

  assign is_ebreak = (diff_Instr == EBREAK_INSTR);
  assign commit    = diff_enable && (state != HALTED);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = rec_valid && rec_ready;
  assign push      = commit && (!full || pop);
  assign rec_valid = (count != '0);
  assign halted    = (state == HALTED);

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FIRST: if (diff_enable) state_nxt = is_ebreak ? HALTED : RUN;
      RUN:        if (diff_enable && is_ebreak) state_nxt = HALTED;
      default:    state_nxt = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_FIRST;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expected_pc  <= RESET_PC;
      retired_cnt  <= '0;
      err_flow     <= 1'b0;
      err_pc       <= '0;
      err_overflow <= 1'b0;
      wdt_cnt      <= '0;
      wdt_timeout  <= 1'b0;
    end else begin
      if (commit) begin
        // expected_pc resyncs to nextPC even after a mismatch
        expected_pc <= nextPC;
        retired_cnt <= retired_cnt + 1'b1;
        if (diff_PC != expected_pc) begin
          err_flow <= 1'b1;
          if (!err_flow) err_pc <= diff_PC;
        end
        if (full && !pop) err_overflow <= 1'b1;
      end
      if (state != HALTED) begin
        if (commit)                                wdt_cnt <= '0;
        else if (wdt_cnt == WW'(WDT_CYCLES - 1))   wdt_timeout <= 1'b1;
        else                                       wdt_cnt <= wdt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= diff_PC;
      instr_mem[wr_ptr] <= diff_Instr;
    end
  end

  // Head registers load the incoming record when it becomes the head directly,
  // otherwise the next stored entry on a pop; they hold while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rec_pc    <= '0;
      rec_instr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && (count == '0 || (pop && count == (AW+1)'(1)))) begin
        rec_pc    <= diff_PC;
        rec_instr <= diff_Instr;
      end else if (pop && count > (AW+1)'(1)) begin
        rec_pc    <= pc_mem[rd_ptr + 1'b1];
        rec_instr <= instr_mem[rd_ptr + 1'b1];
      end
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
// Directed and randomized commit streams checked against a queue-based reference model.
module tb_commit_monitor;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned WDT    = 16;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        diff_enable = 1'b0, rec_ready = 1'b0;
  logic [31:0] diff_PC = '0, diff_Instr = '0, nextPC = '0;
  logic        rec_valid, halted, err_flow, err_overflow, wdt_timeout;
  logic [31:0] rec_pc, rec_instr, retired_cnt, err_pc;

  commit_monitor #(.FIFO_DEPTH(DEPTH), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .diff_enable(diff_enable), .diff_PC(diff_PC),
    .diff_Instr(diff_Instr), .nextPC(nextPC), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_pc(rec_pc), .rec_instr(rec_instr),
    .retired_cnt(retired_cnt), .halted(halted), .err_flow(err_flow),
    .err_pc(err_pc), .err_overflow(err_overflow), .wdt_timeout(wdt_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } rec_t;

  int   total = 0, bad = 0;
  rec_t q[$];
  rec_t m_last;
  logic m_halted, m_flow, m_ovf, m_wdt;
  logic [31:0] m_exp, m_cnt, m_err_pc;
  int   m_idle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = '0; m_halted = 0; m_flow = 0; m_ovf = 0; m_wdt = 0;
    m_exp = 32'h80000000; m_cnt = '0; m_err_pc = '0; m_idle = 0;
  endtask

  task automatic check_all(input string tag);
    rec_t head;
    head = (q.size() != 0) ? q[0] : m_last;
    chk({tag, ".rec_valid"}, 64'(rec_valid), 64'(q.size() != 0));
    chk({tag, ".rec_pc"}, 64'(rec_pc), 64'(head.pc));
    chk({tag, ".rec_instr"}, 64'(rec_instr), 64'(head.instr));
    chk({tag, ".retired_cnt"}, 64'(retired_cnt), 64'(m_cnt));
    chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
    chk({tag, ".err_flow"}, 64'(err_flow), 64'(m_flow));
    chk({tag, ".err_pc"}, 64'(err_pc), 64'(m_err_pc));
    chk({tag, ".err_overflow"}, 64'(err_overflow), 64'(m_ovf));
    chk({tag, ".wdt_timeout"}, 64'(wdt_timeout), 64'(m_wdt));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0; diff_enable = 1'b0; rec_ready = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input string tag, input logic en, input logic [31:0] pc,
                      input logic [31:0] instr, input logic [31:0] npc, input logic rdy);
    rec_t r;
    diff_enable = en; diff_PC = pc; diff_Instr = instr; nextPC = npc; rec_ready = rdy;
    @(posedge clk);
    if (q.size() != 0 && rdy) m_last = q.pop_front();
    if (en && !m_halted) begin
      r.pc = pc; r.instr = instr;
      if (q.size() < DEPTH) q.push_back(r);
      else                  m_ovf = 1'b1;
      if (pc != m_exp) begin
        if (!m_flow) m_err_pc = pc;
        m_flow = 1'b1;
      end
      m_exp = npc;
      m_cnt = m_cnt + 1;
      if (instr == EBREAK) m_halted = 1'b1;
      m_idle = 0;
    end else if (!m_halted) begin
      m_idle++;
      if (m_idle >= WDT) m_wdt = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] pc;
    // basic sequential commits with immediate drain
    do_reset("rst0");
    for (int i = 0; i < 3; i++) step("seq", 1, 32'h80000000 + 32'(4*i), 32'h13 + 32'(i), 32'h80000004 + 32'(4*i), 1);
    step("seq_drain", 0, 0, 0, 0, 1);
    chk("seq_cnt3", 64'(retired_cnt), 64'd3);
    chk("seq_empty", 64'(rec_valid), 64'd0);

    // wrong first PC, then a later mismatch must not move err_pc
    do_reset("rst1");
    step("flow1", 1, 32'h80000010, 32'h1, 32'h80000014, 1);
    chk("flow_errpc", 64'(err_pc), 64'h80000010);
    step("flow2", 1, 32'h80000014, 32'h2, 32'h80000018, 1);
    step("flow3", 1, 32'h80000100, 32'h3, 32'h80000104, 1);
    chk("flow_errpc_kept", 64'(err_pc), 64'h80000010);

    // taken branch followed correctly, then a fall-through that ignores the branch
    do_reset("rst2");
    step("br0", 1, 32'h80000000, 32'h5, 32'h80000020, 1);
    step("br1", 1, 32'h80000020, 32'h6, 32'h80000040, 1);
    step("br2", 1, 32'h80000040, 32'h7, 32'h80000080, 1);
    chk("br_noerr", 64'(err_flow), 64'd0);
    step("br3", 1, 32'h80000044, 32'h8, 32'h80000048, 1);
    chk("br_err", 64'(err_flow), 64'd1);

    // overflow: nine commits into an eight-entry FIFO, then drain
    do_reset("rst3");
    for (int i = 0; i < 9; i++) step("ovf", 1, 32'h80000000 + 32'(4*i), 32'hA0 + 32'(i), 32'h80000004 + 32'(4*i), 0);
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_cnt", 64'(retired_cnt), 64'd9);
    chk("ovf_head", 64'(rec_pc), 64'h80000000);
    for (int i = 0; i < 9; i++) step("ovf_drain", 0, 0, 0, 0, 1);
    chk("ovf_last", 64'(rec_instr), 64'hA7);

    // full FIFO with a simultaneous pop accepts the ninth record
    do_reset("rst4");
    for (int i = 0; i < 8; i++) step("full", 1, 32'h80000000 + 32'(4*i), 32'hB0 + 32'(i), 32'h80000004 + 32'(4*i), 0);
    step("full_pp", 1, 32'h80000020, 32'hB8, 32'h80000024, 1);
    chk("full_noovf", 64'(err_overflow), 64'd0);
    for (int i = 0; i < 9; i++) step("full_drain", 0, 0, 0, 0, 1);

    // ebreak halts; later strobes are ignored
    do_reset("rst5");
    for (int i = 0; i < 3; i++) step("pre_halt", 1, 32'h80000000 + 32'(4*i), 32'h13, 32'h80000004 + 32'(4*i), 0);
    step("halt", 1, 32'h8000000c, EBREAK, 32'h80000010, 0);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_cnt", 64'(retired_cnt), 64'd4);
    for (int i = 0; i < 20; i++) step("post_halt", 1, 32'h90000000 + 32'(i), 32'h13, 32'h0, 0);
    chk("halt_cnt_frozen", 64'(retired_cnt), 64'd4);
    chk("halt_no_wdt", 64'(wdt_timeout), 64'd0);

    // watchdog after idle edges, then asynchronous reset mid-cycle
    do_reset("rst6");
    for (int i = 0; i < WDT - 1; i++) step("wdt_pre", 0, 0, 0, 0, 0);
    chk("wdt_not_yet", 64'(wdt_timeout), 64'd0);
    step("wdt_fire", 0, 0, 0, 0, 0);
    chk("wdt_set", 64'(wdt_timeout), 64'd1);
    step("wdt_sticky", 1, 32'h80000000, 32'h13, 32'h80000004, 0);
    step("wdt_sticky2", 1, 32'h80000010, 32'h13, 32'h80000014, 0);
    do_reset("async_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      pc = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFFFFFC) : m_exp;
      step("rand", ($urandom_range(0, 9) < 6), pc,
           ($urandom_range(0, 299) == 0) ? EBREAK : $urandom,
           ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFFFC) : pc + 32'd4,
           $urandom_range(0, 1) == 1);
      if (m_halted && $urandom_range(0, 9) == 0) do_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
- Consumes the per-instruction commit stream the CPU emits for difftest: diff_enable, diff_PC, diff_Instr, nextPC.
- Checks control-flow continuity, counts retired instructions, detects the ebreak halt and runs a no-commit watchdog.
- Buffers commit records in a FIFO, drained over a valid/ready interface by trace/UART logic in the simulation SoC wrapper next to CPU.

Parameters:
PC_WIDTH, 32, width of PC fields
INSTR_WIDTH, 32, width of instruction field
FIFO_DEPTH, 8, record FIFO entries (power of two, >=2)
CNT_WIDTH, 32, retired-instruction counter width
WDT_CYCLES, 1024, cycles without a commit before timeout
RESET_PC, 32'h80000000, required PC of first commit
EBREAK_INSTR, 32'h00100073, encoding that halts the monitor

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
diff_enable  in  1  commit strobe, one instruction per asserted cycle
diff_PC  in  PC_WIDTH  PC of committing instruction
diff_Instr  in  INSTR_WIDTH  committing instruction word
nextPC  in  PC_WIDTH  architectural successor PC of committing instruction
rec_valid  out  1  FIFO head record available
rec_ready  in  1  consumer accepts head this cycle
rec_pc  out  PC_WIDTH  head record PC
rec_instr  out  INSTR_WIDTH  head record instruction
retired_cnt  out  CNT_WIDTH  accepted commits
halted  out  1  ebreak committed
err_flow  out  1  sticky: PC discontinuity
err_pc  out  PC_WIDTH  PC of first discontinuous commit
err_overflow  out  1  sticky: record dropped, FIFO full
wdt_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset (rst=0, async): state=WAIT_FIRST, expected_pc=RESET_PC, FIFO empty, wdt counter=0. All outputs 0, including rec_pc, rec_instr and err_pc.
- "Commit": diff_enable=1 on a rising edge while state is not HALTED.
- States:
  - WAIT_FIRST: first commit moves to RUN, or to HALTED if diff_Instr==EBREAK_INSTR.
  - RUN: a commit with diff_Instr==EBREAK_INSTR moves to HALTED; otherwise stays in RUN.
  - HALTED: absorbing until reset. diff_enable is ignored: no count, no push, no check.
- Continuity check on every commit:
  - If diff_PC != expected_pc, set err_flow. Capture err_pc only on the first error (err_flow was 0).
  - After every commit, expected_pc <= nextPC, regardless of mismatch (resync).
- retired_cnt increments by 1 per commit, ebreak included. Wraps modulo 2^CNT_WIDTH.
- halted goes to 1 on the edge that accepts the ebreak commit.
- FIFO:
  - Each commit pushes {diff_PC, diff_Instr}.
  - rec_valid = FIFO not empty. rec_pc/rec_instr are registered head contents.
  - A record pushed at edge N is visible at the head after edge N (first-word latency 1 cycle).
  - Pop when rec_valid && rec_ready.
  - Full with simultaneous pop: push and pop both succeed, occupancy unchanged.
  - Full with no pop: record dropped, err_overflow set. retired_cnt and continuity check still update.
  - Empty: rec_ready ignored. rec_pc/rec_instr hold their last values.
- Watchdog:
  - In WAIT_FIRST/RUN the counter clears on a commit, else increments.
  - When the counter reaches WDT_CYCLES-1 without a commit, wdt_timeout sets on the next edge; the counter saturates.
  - Frozen in HALTED.
  - A later commit does not clear wdt_timeout.
- Sticky flags clear only on reset. Reset mid-operation discards FIFO contents and all counters immediately.

Test Plan:
- Reset release, commits at PC 0x80000000, 0x80000004, 0x80000008 with nextPC=PC+4, rec_ready=1 -> retired_cnt=3, three records in order, err_flow=0, rec_valid low after drain.
- First commit PC 0x80000010 -> err_flow=1, err_pc=0x80000010. A later mismatch at 0x80000100 -> err_pc unchanged.
- Branch commit PC 0x80000020 with nextPC 0x80000040, next commit PC 0x80000040 -> no error. Next commit PC 0x80000044 instead -> err_flow=1.
- rec_ready=0, 9 commits with FIFO_DEPTH=8 -> err_overflow=1, retired_cnt=9, drain yields first 8 records only. Repeat 8 commits, then a 9th with rec_ready=1 in the same cycle -> no overflow.
- Commit 0x00100073 at PC 0x8000000c -> halted=1 next cycle, retired_cnt includes it, record present. Further diff_enable pulses change nothing.
- WDT_CYCLES=16, no commits after reset -> wdt_timeout=1 after 16 edges. rst pulsed low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
